// File: rtl/approx_mul_rr_sched_pkg.sv
// Shared types and constants for the round-robin scheduler around the truncated multiplier.
package approx_mul_pkg;

  localparam int OPND_W   = 32;
  localparam int PROD_W   = 64;
  localparam int TRUNC_L  = 10;
  localparam int COMP_BIT = 13;
  // Widest tag the pipeline carries; covers up to 8 requesters.
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [PROD_W-1:0]   z;
  } pipe_entry_t;

endpackage

// File: rtl/approx_mul_rr_sched_if.sv
// Request/response bundle between the requesters, the scheduler and the result consumer.
interface approx_mul_rr_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_x;
  logic [32*N_REQ-1:0] req_y;
  logic [N_REQ-1:0]    req_exact;
  logic                resp_valid;
  logic                resp_ready;
  logic [ID_W-1:0]     resp_id;
  logic [63:0]         resp_z;

  modport master (
    output req_valid, req_x, req_y, req_exact, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_z
  );

  modport slave (
    input  req_valid, req_x, req_y, req_exact, resp_ready,
    output req_ready, resp_valid, resp_id, resp_z
  );

endinterface

// File: rtl/approx_mul_rr_sched_core.sv
// Combinational 32x32 multiplier: exact product, or x truncated below TRUNC_L plus a
// single-bit compensation term at COMP_BIT. No state, no backpressure.
module approx_mul_core
  import approx_mul_pkg::*;
(
  input  logic [OPND_W-1:0] x_i,
  input  logic [OPND_W-1:0] y_i,
  input  logic              exact_i,
  output logic [PROD_W-1:0] z_o
);

  logic [PROD_W-1:0] exact_p;
  logic [PROD_W-1:0] trunc_p;
  logic [PROD_W-1:0] comp;

  always_comb begin
    exact_p = {{(PROD_W-OPND_W){1'b0}}, x_i} * {{(PROD_W-OPND_W){1'b0}}, y_i};
    trunc_p = ({{(PROD_W-OPND_W){1'b0}}, y_i} *
               {{(PROD_W-OPND_W+TRUNC_L){1'b0}}, x_i[OPND_W-1:TRUNC_L]}) << TRUNC_L;
    // Recovers part of the dropped low partial products when these four bits line up.
    comp           = '0;
    comp[COMP_BIT] = x_i[2] & y_i[10] & x_i[3] & y_i[9];
    z_o            = exact_i ? exact_p : (trunc_p + comp);
  end

endmodule

// File: rtl/approx_mul_rr_sched.sv
// Round-robin share of one multiplier among N_REQ requesters; result LAT cycles after accept.
// A stalled output (resp_valid & ~resp_ready) freezes every stage and blocks all accepts.
module approx_mul_rr_sched
  import approx_mul_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LAT   = 2,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  approx_mul_rr_sched_if.slave  bus,
  output logic                  busy,
  output logic [31:0]           issue_cnt
);

  pipe_entry_t       pipe_q [LAT];
  pipe_entry_t       pipe_d [LAT];
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]       issue_cnt_q, issue_cnt_d;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic              stall;
  logic              adv;
  logic              accept;
  logic [OPND_W-1:0] sel_x;
  logic [OPND_W-1:0] sel_y;
  logic              sel_exact;
  logic [PROD_W-1:0] prod;

  assign stall = pipe_q[LAT-1].valid & ~bus.resp_ready;
  assign adv   = ~stall;

  // Search starts at rr_ptr and wraps, so the last winner goes to the back of the line.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_any && bus.req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
        gnt_any                              = 1'b1;
        gnt_idx                              = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
        grant[(int'(rr_ptr_q) + k) % N_REQ]  = 1'b1;
      end
    end
  end

  assign accept        = adv & gnt_any & ~rst;
  assign bus.req_ready = grant & {N_REQ{adv & ~rst}};

  assign sel_x     = bus.req_x[{gnt_idx, 5'd0} +: OPND_W];
  assign sel_y     = bus.req_y[{gnt_idx, 5'd0} +: OPND_W];
  assign sel_exact = bus.req_exact[gnt_idx];

  approx_mul_core u_core (
    .x_i     (sel_x),
    .y_i     (sel_y),
    .exact_i (sel_exact),
    .z_o     (prod)
  );

  // Payload only moves with a valid entry, so the output holds its last result across bubbles.
  always_comb begin
    pipe_d      = pipe_q;
    rr_ptr_d    = rr_ptr_q;
    issue_cnt_d = issue_cnt_q;
    if (adv) begin
      pipe_d[0].valid = accept;
      if (accept) begin
        pipe_d[0].id = ID_MAX_W'(gnt_idx);
        pipe_d[0].z  = prod;
      end
      for (int s = 1; s < LAT; s++) begin
        pipe_d[s].valid = pipe_q[s-1].valid;
        if (pipe_q[s-1].valid) begin
          pipe_d[s].id = pipe_q[s-1].id;
          pipe_d[s].z  = pipe_q[s-1].z;
        end
      end
    end
    if (accept) begin
      rr_ptr_d    = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
      issue_cnt_d = issue_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        pipe_q[s] <= '0;
      end
      rr_ptr_q    <= '0;
      issue_cnt_q <= '0;
    end else begin
      pipe_q      <= pipe_d;
      rr_ptr_q    <= rr_ptr_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < LAT; s++) begin
      busy = busy | pipe_q[s].valid;
    end
  end

  assign bus.resp_valid = pipe_q[LAT-1].valid;
  assign bus.resp_id    = ID_W'(pipe_q[LAT-1].id);
  assign bus.resp_z     = pipe_q[LAT-1].z;
  assign issue_cnt      = issue_cnt_q;

endmodule

// File: tb/tb_approx_mul_rr_sched.sv
// Bench for approx_mul_rr_sched: directed literal cases plus randomized traffic,
// all outputs compared every cycle against an age-based queue model.
module tb_approx_mul_rr_sched;

  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int IDW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [31:0] issue_cnt;

  approx_mul_rr_sched_if #(.N_REQ(N), .ID_W(IDW)) bus_if ();

  approx_mul_rr_sched #(.N_REQ(N), .LAT(LAT), .ID_W(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .busy      (busy),
    .issue_cnt (issue_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] z;
    int          age;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  bit          done   = 1'b0;
  exp_t        q[$];
  int          m_ptr;
  logic [31:0] m_cnt;
  int          last_id;
  logic [63:0] last_z;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_z(input logic [31:0] x, input logic [31:0] y, input logic ex);
    logic [63:0] xs;
    logic [63:0] ys;
    xs = {32'd0, x};
    ys = {32'd0, y};
    if (ex) return xs * ys;
    return ((ys * (xs >> 10)) << 10) + ((x[2] && y[10] && x[3] && y[9]) ? 64'h2000 : 64'h0);
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr   = 0;
    m_cnt   = 0;
    last_id = 0;
    last_z  = 0;
  endtask

  // An entry is at the output once it has seen LAT non-stalled edges since acceptance.
  task automatic compare_loop();
    bit          ev;
    bit          stall;
    logic [N-1:0] erdy;
    int          g;
    exp_t        e;
    model_reset();
    while (!done) begin
      @(negedge clk);
      if (rst) begin
        chk("rst_resp_valid", bus_if.resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_issue_cnt", issue_cnt, 0);
        chk("rst_req_ready", bus_if.req_ready, 0);
        chk("rst_resp_id", bus_if.resp_id, 0);
        chk("rst_resp_z", bus_if.resp_z, 0);
        model_reset();
      end else begin
        ev = (q.size() > 0) && (q[0].age >= LAT);
        chk("resp_valid", bus_if.resp_valid, ev);
        if (ev) begin
          chk("resp_id", bus_if.resp_id, q[0].id);
          chk("resp_z", bus_if.resp_z, q[0].z);
        end else begin
          chk("hold_resp_id", bus_if.resp_id, last_id);
          chk("hold_resp_z", bus_if.resp_z, last_z);
        end
        chk("busy", busy, q.size() != 0);
        chk("issue_cnt", issue_cnt, m_cnt);
        stall = ev && !bus_if.resp_ready;
        erdy  = '0;
        g     = -1;
        if (!stall) begin
          for (int k = 0; k < N; k++) begin
            if (g < 0 && bus_if.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
          end
          if (g >= 0) erdy[g] = 1'b1;
        end
        chk("req_ready", bus_if.req_ready, erdy);
        if (ev) begin
          last_id = q[0].id;
          last_z  = q[0].z;
        end
        if (!stall) begin
          if (ev) void'(q.pop_front());
          for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
          if (g >= 0) begin
            e.id  = g;
            e.z   = ref_z(bus_if.req_x[32*g +: 32], bus_if.req_y[32*g +: 32], bus_if.req_exact[g]);
            e.age = 1;
            q.push_back(e);
            m_cnt = m_cnt + 32'd1;
            m_ptr = (g + 1) % N;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y, input logic ex);
    bus_if.req_x[32*i +: 32] = x;
    bus_if.req_y[32*i +: 32] = y;
    bus_if.req_exact[i]      = ex;
  endtask

  task automatic rand_ops();
    logic [31:0] xv;
    logic [31:0] yv;
    for (int i = 0; i < N; i++) begin
      xv = $urandom;
      yv = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        xv[3:2]  = 2'b11;
        yv[10:9] = 2'b11;
      end
      if ($urandom_range(0, 5) == 0) xv = xv & 32'h3FF;
      set_op(i, xv, yv, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    bus_if.req_valid  = '0;
    bus_if.resp_ready = 1'b1;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk(name, busy, 0);
  endtask

  task automatic stimulus();
    logic [3:0] oh;
    // Reset with all requests raised: nothing may be granted.
    bus_if.req_valid = '1;
    #1;
    chk("reset_req_ready", bus_if.req_ready, 0);
    chk("reset_resp_valid", bus_if.resp_valid, 0);
    chk("reset_issue_cnt", issue_cnt, 0);
    bus_if.req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Single approximate request from requester 0.
    tick();
    set_op(0, 32'h0000_0400, 32'd3, 1'b0);
    bus_if.req_valid = 4'b0001;
    #1 chk("t1_req_ready", bus_if.req_ready, 4'b0001);
    tick();
    bus_if.req_valid = '0;
    #1 chk("t1_not_yet", bus_if.resp_valid, 0);
    tick();
    #1;
    chk("t1_resp_valid", bus_if.resp_valid, 1);
    chk("t1_resp_id", bus_if.resp_id, 0);
    chk("t1_resp_z", bus_if.resp_z, 64'hC00);
    chk("t1_issue_cnt", issue_cnt, 1);

    // Compensation bit alone, then the exact product of the same operands.
    tick();
    set_op(2, 32'h0000_03FF, 32'hFFFF_FFFF, 1'b0);
    bus_if.req_valid = 4'b0100;
    tick();
    bus_if.req_exact[2] = 1'b1;
    tick();
    bus_if.req_valid = '0;
    #1;
    chk("t2_approx_z", bus_if.resp_z, 64'h2000);
    chk("t2_approx_id", bus_if.resp_id, 2);
    tick();
    #1;
    chk("t2_exact_z", bus_if.resp_z, 64'h3FE_FFFF_FC01);
    chk("t2_issue_cnt", issue_cnt, 3);

    // All requesters valid straight out of reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      rand_ops();
      bus_if.req_valid = '1;
      oh = 4'b0001 << (k % 4);
      #1 chk("t3_grant", bus_if.req_ready, oh);
      if (k >= 2) begin
        chk("t3_resp_valid", bus_if.resp_valid, 1);
        chk("t3_resp_id", bus_if.resp_id, (k - 2) % 4);
      end
    end

    // Hold the output for five cycles with a full pipeline.
    for (int k = 0; k < 5; k++) begin
      tick();
      rand_ops();
      bus_if.resp_ready = 1'b0;
      #1;
      chk("t4_req_ready", bus_if.req_ready, 0);
      chk("t4_resp_id", bus_if.resp_id, 0);
      chk("t4_resp_valid", bus_if.resp_valid, 1);
    end
    tick();
    bus_if.resp_ready = 1'b1;
    tick();
    drain("t4_drain");

    // Reset with two entries in flight.
    tick();
    rand_ops();
    bus_if.req_valid = 4'b0011;
    tick();
    tick();
    bus_if.req_valid = '0;
    #2 rst = 1'b1;
    #1;
    chk("t5_resp_valid", bus_if.resp_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_issue_cnt", issue_cnt, 0);
    tick();
    tick();
    rst = 1'b0;
    bus_if.req_valid = 4'b1010;
    #1 chk("t5_first_grant", bus_if.req_ready, 4'b0010);
    tick();
    bus_if.req_valid = '0;
    tick();
    #1 chk("t5_resp_id", bus_if.resp_id, 1);
    drain("t5_drain");

    // Counter wrap from the all-ones value.
    tick();
    force dut.issue_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1 release dut.issue_cnt_q;
    #1 chk("t6_preload", issue_cnt, 32'hFFFF_FFFF);
    tick();
    bus_if.req_valid = 4'b0001;
    tick();
    bus_if.req_valid = '0;
    #1 chk("t6_wrap", issue_cnt, 0);
    drain("t6_drain");

    // Random traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      tick();
      rand_ops();
      bus_if.req_valid  = 4'($urandom_range(0, 15));
      bus_if.resp_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    drain("rand_drain");
    chk("rand_queue_empty", q.size(), 0);

    done = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    rst               = 1'b1;
    bus_if.req_valid  = '0;
    bus_if.req_x      = '0;
    bus_if.req_y      = '0;
    bus_if.req_exact  = '0;
    bus_if.resp_ready = 1'b1;
    fork
      compare_loop();
      stimulus();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/approx_mul_rr_sched.md
Name: approx_mul_rr_sched

Overview:
Round-robin scheduler that time-shares one unsigned 32x32 truncated approximate multiplier (truncation level 10) among N_REQ requesters.
- Arbitrates valid/ready requests and issues at most one multiply per cycle into a LAT-stage pipeline.
- Returns each 64-bit product tagged with the requester index, under one global backpressure stall.
- Sits between requesting datapath units and the shared multiplier; a per-request mode bit selects approximate or exact product.

Parameters:
N_REQ, 4, number of requesters (2..8)
LAT, 2, pipeline stages from accept to result (1..4)
ID_W, 2, requester tag width, equal to clog2(N_REQ)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  N_REQ  request valid, one bit per requester
req_ready  output  N_REQ  request accepted this cycle, at most one bit set
req_x  input  32*N_REQ  multiplier operand x, requester i at bits [32i+31:32i]
req_y  input  32*N_REQ  multiplicand y, same packing as req_x
req_exact  input  N_REQ  1 = exact product, 0 = approximate product
resp_valid  output  1  result valid
resp_ready  input  1  consumer accepts the result
resp_id  output  ID_W  requester index of the result
resp_z  output  64  product
busy  output  1  any pipeline stage holds a valid entry
issue_cnt  output  32  count of accepted requests, wraps at 2^32

Behaviour:
- Reset, asynchronous, active-high:
  - all stage valid bits = 0, so resp_valid = 0 and busy = 0
  - resp_id = 0, resp_z = 0, issue_cnt = 0, rr_ptr = 0
  - req_ready = 0 while rst is asserted
- Reset mid-operation discards all in-flight entries. No response is produced for them.
- stall = resp_valid & ~resp_ready; adv = ~stall.
- When adv = 1, every stage shifts forward by one. When stall = 1, every stage holds.
- Arbitration is combinational and round-robin:
  - grant goes to the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ..., wrapping mod N_REQ
  - req_ready[i] = adv & grant[i]
  - on accept, rr_ptr <= (granted index + 1) mod N_REQ; otherwise rr_ptr holds
- Arithmetic, computed combinationally from the granted operands in the accept cycle:
  - exact: z = x*y
  - approximate: z = ((y * x[31:10]) << 10) + ((x[2] & y[10] & x[3] & y[9]) << 13)
  - all widths unsigned; result is 64 bits; the compensation term occupies bit 13 only
- Pipeline:
  - the accept-cycle result {id, z} is registered into stage 1 and moves one stage per adv cycle
  - stage LAT drives resp_*
  - latency without stalls: resp_valid rises LAT cycles after the req_valid & req_ready cycle
- Throughput is one accept per cycle. Empty bubbles advance freely.
- While stalled:
  - no request is accepted
  - resp_id and resp_z are held stable until resp_ready
- Issue and retire in the same cycle (full pipeline, resp_ready = 1): legal and lossless.
- issue_cnt increments on each accept and wraps 0xFFFFFFFF -> 0.
- busy = OR of all stage valid bits.
- resp_z and resp_id hold their last value when resp_valid = 0.
- The scheduler never reorders: responses retire in accept order.

Decomposition:
- Package approx_mul_pkg holds:
  - constants TRUNC_L = 10, COMP_BIT = 13, PROD_W = 64
  - typedef pipe_entry_t {valid, id, z}
- Sub-module approx_mul_core (combinational): inputs x, y, exact; output z.
- Scheduler top holds the arbiter, the pipeline registers and the counters.

Test Plan:
1. Single request, req 0: x=0x00000400, y=3, exact=0 -> resp_valid after LAT=2 cycles, resp_id=0, resp_z=0xC00; issue_cnt=1.
2. Compensation check, req 2: x=0x000003FF, y=0xFFFFFFFF, exact=0 -> resp_z=0x2000. Same operands with exact=1 -> resp_z=0x3FEFFFFFC01.
3. All 4 requesters valid continuously from reset -> grant order 0,1,2,3,0,1 on consecutive cycles; resp_id sequence identical, offset by 2 cycles.
4. Backpressure: resp_ready=0 for 5 cycles with pipeline full -> req_ready all 0 and resp_z/resp_id stable; on release, results retire in order with no loss or duplication.
5. Reset mid-operation: assert rst with 2 entries in flight -> resp_valid=0, busy=0, issue_cnt=0 immediately. After release, requests valid on 1 and 3 -> requester 1 is granted first (rr_ptr=0).
6. issue_cnt preloaded near wrap by driving 2^32-1 accepts (or via force) -> next accept gives issue_cnt=0.
